// File: rtl/mandel_scan_engine.sv
// Mandelbrot scanline engine: iterates z <= z^2 + c for each pixel of a row
// and streams iteration counts over a valid/ready handshake.
// Optional feature macro: MANDEL_JULIA_EN (Julia-set constant c registers).
`timescale 1ns/1ps
module mandel_scan_engine #(
  parameter int BITS   = 16,
  parameter int ITER_W = 4,
  parameter int COLS   = 640
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic                      row_start,
  input  logic                      cfg_we,
  input  logic [2:0]                cfg_addr,
  input  logic [BITS-1:0]           cfg_data,
  output logic                      px_valid,
  input  logic                      px_ready,
  output logic [ITER_W-1:0]         px_iter,
  output logic                      px_inside,
  output logic [$clog2(COLS)-1:0]   px_col,
  output logic                      busy
);
  localparam int CW   = $clog2(COLS);
  localparam int FRAC = BITS - 3;
  localparam logic signed [BITS-1:0] TWO_FX     = BITS'(2) << FRAC;
  localparam logic signed [BITS-1:0] NEG_TWO_FX = -TWO_FX;
  localparam logic signed [BITS-1:0] Y_TOP_RST  = BITS'(3) << (FRAC - 1);
  localparam logic signed [BITS-1:0] INC_RST    = BITS'(1) << (FRAC - 7);
  localparam logic [2*BITS:0]        R2_LIMIT   = (2*BITS+1)'(1) << (2*FRAC + 2);
  localparam logic [ITER_W-1:0]      MAX_ITER   = {ITER_W{1'b1}};
  localparam logic [CW-1:0]          LAST_COL   = CW'(COLS - 1);

  typedef enum logic [1:0] {IDLE, INIT, ITER, OUT} state_t;
  state_t state_reg;

  logic signed [BITS-1:0] sh_x_left_reg, sh_y_top_reg, sh_x_inc_reg, sh_y_inc_reg;
  logic signed [BITS-1:0] x_left_reg, y_top_reg, x_inc_reg, y_inc_reg;
  logic signed [BITS-1:0] x0_reg, y0_reg, zx_reg, zy_reg;
  logic [ITER_W-1:0]      iter_reg;
  logic [CW-1:0]          col_reg;
  logic                   px_valid_reg, px_inside_reg;
  logic [ITER_W-1:0]      px_iter_reg;
  logic [CW-1:0]          px_col_reg;

  logic signed [BITS-1:0] cr, ci;
`ifdef MANDEL_JULIA_EN
  logic signed [BITS-1:0] sh_julia_cr_reg, sh_julia_ci_reg, julia_cr_reg, julia_ci_reg;
  logic                   sh_julia_mode_reg, julia_mode_reg;
  assign cr = julia_mode_reg ? julia_cr_reg : x0_reg;
  assign ci = julia_mode_reg ? julia_ci_reg : y0_reg;
`else
  assign cr = x0_reg;
  assign ci = y0_reg;
`endif

  // Full-precision products; escape test uses them before any truncation.
  logic signed [2*BITS-1:0] xx, yy, xy;
  logic [2*BITS:0]          r2;
  logic                     esc;
  logic signed [BITS-1:0]   zx_next, zy_next;
  logic                     unused_xy_bits;
  assign xx = zx_reg * zx_reg;
  assign yy = zy_reg * zy_reg;
  assign xy = zx_reg * zy_reg;
  assign r2 = {1'b0, xx} + {1'b0, yy};
  assign esc = (zx_reg >= TWO_FX) || (zx_reg <= NEG_TWO_FX) ||
               (zy_reg >= TWO_FX) || (zy_reg <= NEG_TWO_FX) || (r2 >= R2_LIMIT);
  // 2xy is taken one bit lower so the doubled product is truncated once.
  assign zx_next = xx[FRAC+BITS-1:FRAC] - yy[FRAC+BITS-1:FRAC] + cr;
  assign zy_next = xy[FRAC+BITS-2:FRAC-1] + ci;
  assign unused_xy_bits = ^{xy[FRAC-2:0], xy[2*BITS-1:FRAC+BITS-1]};

  assign px_valid  = px_valid_reg;
  assign px_iter   = px_iter_reg;
  assign px_inside = px_inside_reg;
  assign px_col    = px_col_reg;
  assign busy      = (state_reg != IDLE);

  // Shadow viewport registers: written by the config port, consumed at frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_x_left_reg <= NEG_TWO_FX;
      sh_y_top_reg  <= Y_TOP_RST;
      sh_x_inc_reg  <= INC_RST;
      sh_y_inc_reg  <= INC_RST;
`ifdef MANDEL_JULIA_EN
      sh_julia_cr_reg   <= '0;
      sh_julia_ci_reg   <= '0;
      sh_julia_mode_reg <= 1'b0;
`endif
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0: sh_x_left_reg <= cfg_data;
        3'd1: sh_y_top_reg  <= cfg_data;
        3'd2: sh_x_inc_reg  <= cfg_data;
        3'd3: sh_y_inc_reg  <= cfg_data;
`ifdef MANDEL_JULIA_EN
        3'd4: sh_julia_cr_reg   <= cfg_data;
        3'd5: sh_julia_ci_reg   <= cfg_data;
        3'd6: sh_julia_mode_reg <= cfg_data[0];
`endif
        default: ;
      endcase
    end
  end

  // Scan FSM: frame/row pulses override everything, then INIT -> ITER -> OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      x_left_reg    <= NEG_TWO_FX;
      y_top_reg     <= Y_TOP_RST;
      x_inc_reg     <= INC_RST;
      y_inc_reg     <= INC_RST;
`ifdef MANDEL_JULIA_EN
      julia_cr_reg   <= '0;
      julia_ci_reg   <= '0;
      julia_mode_reg <= 1'b0;
`endif
      x0_reg        <= '0;
      y0_reg        <= '0;
      zx_reg        <= '0;
      zy_reg        <= '0;
      iter_reg      <= '0;
      col_reg       <= '0;
      px_valid_reg  <= 1'b0;
      px_iter_reg   <= '0;
      px_inside_reg <= 1'b0;
      px_col_reg    <= '0;
    end else if (frame_start) begin
      x_left_reg   <= sh_x_left_reg;
      y_top_reg    <= sh_y_top_reg;
      x_inc_reg    <= sh_x_inc_reg;
      y_inc_reg    <= sh_y_inc_reg;
`ifdef MANDEL_JULIA_EN
      julia_cr_reg   <= sh_julia_cr_reg;
      julia_ci_reg   <= sh_julia_ci_reg;
      julia_mode_reg <= sh_julia_mode_reg;
`endif
      x0_reg       <= sh_x_left_reg;
      y0_reg       <= sh_y_top_reg;
      col_reg      <= '0;
      px_valid_reg <= 1'b0;
      state_reg    <= INIT;
    end else if (row_start) begin
      x0_reg       <= x_left_reg;
      y0_reg       <= y0_reg - y_inc_reg;
      col_reg      <= '0;
      px_valid_reg <= 1'b0;
      state_reg    <= INIT;
    end else begin
      case (state_reg)
        IDLE: ;
        INIT: begin
          zx_reg    <= x0_reg;
          zy_reg    <= y0_reg;
          iter_reg  <= '0;
          state_reg <= ITER;
        end
        ITER: begin
          if (esc || (iter_reg == MAX_ITER)) begin
            px_valid_reg  <= 1'b1;
            px_iter_reg   <= iter_reg;
            px_inside_reg <= !esc;
            px_col_reg    <= col_reg;
            state_reg     <= OUT;
          end else begin
            zx_reg   <= zx_next;
            zy_reg   <= zy_next;
            iter_reg <= iter_reg + 1'b1;
          end
        end
        OUT: begin
          if (px_ready) begin
            px_valid_reg <= 1'b0;
            x0_reg       <= x0_reg + x_inc_reg;
            if (col_reg == LAST_COL) begin
              state_reg <= IDLE;
            end else begin
              col_reg   <= col_reg + 1'b1;
              state_reg <= INIT;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mandel_scan_engine.sv
// Directed self-checking bench for mandel_scan_engine (BITS=16, ITER_W=4, COLS=640).
`timescale 1ns/1ps
module tb_mandel_scan_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        row_start = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = 3'd0;
  logic [15:0] cfg_data = 16'd0;
  logic        px_valid;
  logic        px_ready = 1'b0;
  logic [3:0]  px_iter;
  logic        px_inside;
  logic [9:0]  px_col;
  logic        busy;

  int checks = 0;
  int failures = 0;

  mandel_scan_engine #(.BITS(16), .ITER_W(4), .COLS(640)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .row_start(row_start),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .px_valid(px_valid), .px_ready(px_ready), .px_iter(px_iter),
    .px_inside(px_inside), .px_col(px_col), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_frame;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Cycles from the current point until px_valid is seen (bounded).
  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!px_valid && cyc < 64);
    checks++;
    if (!px_valid) begin
      failures++;
      $display("FAIL wait_valid timeout got=%0b exp=1", px_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (px_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", px_valid); end
    checks++; if (px_iter !== 4'd0) begin failures++; $display("FAIL rst_iter got=%0d exp=0", px_iter); end
    checks++; if (px_inside !== 1'b0) begin failures++; $display("FAIL rst_inside got=%0b exp=0", px_inside); end
    checks++; if (px_col !== 10'd0) begin failures++; $display("FAIL rst_col got=%0d exp=0", px_col); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    $display("reset: valid=%0b busy=%0b", px_valid, busy);
  endtask

  task automatic test_first_pixel;
    int cyc;
    pulse_frame();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy got=%0b exp=1", busy); end
    wait_valid(cyc);
    checks++; if (cyc != 2) begin failures++; $display("FAIL t1_latency got=%0d exp=2", cyc); end
    checks++; if (px_iter !== 4'd0) begin failures++; $display("FAIL t1_iter got=%0d exp=0", px_iter); end
    checks++; if (px_inside !== 1'b0) begin failures++; $display("FAIL t1_inside got=%0b exp=0", px_inside); end
    checks++; if (px_col !== 10'd0) begin failures++; $display("FAIL t1_col got=%0d exp=0", px_col); end
    $display("first_pixel: cyc=%0d iter=%0d inside=%0b col=%0d", cyc, px_iter, px_inside, px_col);
  endtask

  task automatic test_inside_row;
    int cyc;
    int bad;
    cfg_write(3'd0, 16'h0000);
    cfg_write(3'd1, 16'h0000);
    cfg_write(3'd2, 16'h0000);
    pulse_frame();
    wait_valid(cyc);
    checks++; if (cyc != 17) begin failures++; $display("FAIL t2_latency got=%0d exp=17", cyc); end
    checks++; if (px_iter !== 4'd15) begin failures++; $display("FAIL t2_iter got=%0d exp=15", px_iter); end
    checks++; if (px_inside !== 1'b1) begin failures++; $display("FAIL t2_inside got=%0b exp=1", px_inside); end
    $display("inside_row: col0 cyc=%0d iter=%0d inside=%0b", cyc, px_iter, px_inside);
    px_ready = 1'b1;
    bad = 0;
    for (int i = 1; i < 640; i++) begin
      wait_valid(cyc);
      if (cyc != 18 || px_col !== 10'(i) || px_iter !== 4'd15 || px_inside !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL t2_row_pixels got=%0d bad exp=0", bad); end
    tick();
    px_ready = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t2_busy_end got=%0b exp=0", busy); end
    checks++; if (px_valid !== 1'b0) begin failures++; $display("FAIL t2_valid_end got=%0b exp=0", px_valid); end
    $display("inside_row: 640 pixels bad=%0d busy=%0b", bad, busy);
    // Write coincident with frame_start: frame uses the old y_top (0).
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 16'h4000; frame_start = 1'b1;
    tick();
    cfg_we = 1'b0; frame_start = 1'b0;
    wait_valid(cyc);
    checks++; if (px_iter !== 4'd15) begin failures++; $display("FAIL shadow_coincident got=%0d exp=15", px_iter); end
    pulse_frame();
    wait_valid(cyc);
    checks++; if (px_iter !== 4'd0) begin failures++; $display("FAIL shadow_next_frame got=%0d exp=0", px_iter); end
    $display("shadow: next-frame iter=%0d", px_iter);
  endtask

  task automatic test_boundary_stall;
    int cyc;
    int unstable;
    cfg_write(3'd0, 16'h2000);
    cfg_write(3'd1, 16'h0000);
    cfg_write(3'd2, 16'h2000);
    pulse_frame();
    wait_valid(cyc);
    checks++; if (cyc != 3) begin failures++; $display("FAIL t3_latency got=%0d exp=3", cyc); end
    checks++; if (px_iter !== 4'd1) begin failures++; $display("FAIL t3_iter got=%0d exp=1", px_iter); end
    checks++; if (px_inside !== 1'b0) begin failures++; $display("FAIL t3_inside got=%0b exp=0", px_inside); end
    $display("boundary: cyc=%0d iter=%0d inside=%0b", cyc, px_iter, px_inside);
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (px_valid !== 1'b1 || px_iter !== 4'd1 || px_inside !== 1'b0 || px_col !== 10'd0) unstable++;
    end
    checks++; if (unstable != 0) begin failures++; $display("FAIL t4_stall_stable got=%0d exp=0", unstable); end
    px_ready = 1'b1;
    wait_valid(cyc);
    px_ready = 1'b0;
    checks++; if (px_col !== 10'd1) begin failures++; $display("FAIL t4_next_col got=%0d exp=1", px_col); end
    checks++; if (px_iter !== 4'd0) begin failures++; $display("FAIL t4_next_iter got=%0d exp=0", px_iter); end
    $display("stall: unstable=%0d next col=%0d iter=%0d", unstable, px_col, px_iter);
  endtask

  task automatic test_row_start;
    int cyc;
    cfg_write(3'd0, 16'h0000);
    cfg_write(3'd1, 16'h4000);
    cfg_write(3'd2, 16'h0000);
    cfg_write(3'd3, 16'h2000);
    pulse_frame();
    px_ready = 1'b1;
    for (int i = 0; i < 5; i++) wait_valid(cyc);
    checks++; if (px_col !== 10'd4) begin failures++; $display("FAIL t5_col4 got=%0d exp=4", px_col); end
    tick();
    tick();
    row_start = 1'b1;
    tick();
    row_start = 1'b0;
    checks++; if (px_valid !== 1'b0) begin failures++; $display("FAIL t5_abort_valid got=%0b exp=0", px_valid); end
    wait_valid(cyc);
    checks++; if (px_col !== 10'd0) begin failures++; $display("FAIL t5_row_col got=%0d exp=0", px_col); end
    checks++; if (px_iter !== 4'd15 || px_inside !== 1'b1) begin failures++; $display("FAIL t5_row_y0 got=%0d/%0b exp=15/1", px_iter, px_inside); end
    $display("row_start: col=%0d iter=%0d inside=%0b", px_col, px_iter, px_inside);
    frame_start = 1'b1; row_start = 1'b1;
    tick();
    frame_start = 1'b0; row_start = 1'b0;
    wait_valid(cyc);
    px_ready = 1'b0;
    checks++; if (px_iter !== 4'd0 || cyc != 2) begin failures++; $display("FAIL t5_frame_wins got=%0d cyc=%0d exp=0 cyc=2", px_iter, cyc); end
    $display("frame_vs_row: iter=%0d cyc=%0d", px_iter, cyc);
  endtask

  task automatic test_julia;
    int cyc;
    cfg_write(3'd4, 16'h0000);
    cfg_write(3'd5, 16'h0000);
    cfg_write(3'd6, 16'h0001);
    cfg_write(3'd0, 16'h1000);
    cfg_write(3'd1, 16'h0000);
    cfg_write(3'd2, 16'h0000);
    pulse_frame();
    wait_valid(cyc);
`ifdef MANDEL_JULIA_EN
    checks++; if (px_iter !== 4'd15 || px_inside !== 1'b1) begin failures++; $display("FAIL t6_julia got=%0d/%0b exp=15/1", px_iter, px_inside); end
`else
    checks++; if (px_iter !== 4'd4 || px_inside !== 1'b0) begin failures++; $display("FAIL t6_mandel got=%0d/%0b exp=4/0", px_iter, px_inside); end
`endif
    $display("julia_cfg: iter=%0d inside=%0b cyc=%0d", px_iter, px_inside, cyc);
  endtask

  task automatic test_reset_mid;
    int pulses;
    cfg_write(3'd0, 16'h0000);
    cfg_write(3'd1, 16'h0000);
    pulse_frame();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || px_valid !== 1'b0) begin failures++; $display("FAIL rst_mid got=%0b/%0b exp=0/0", busy, px_valid); end
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (px_valid !== 1'b0) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL rst_mid_pulse got=%0d exp=0", pulses); end
    $display("reset_mid: busy=%0b pulses=%0d", busy, pulses);
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_inside_row();
    test_boundary_stall();
    test_row_start();
    test_julia();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
